// File: rtl/maxnet_pkg.sv
// Shared types and sizes for the winner-take-all sequencing controller.
package maxnet_pkg;
  localparam int N_NODES = 4;
  localparam int IDX_W   = 2;
  localparam int DATA_W  = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD1 = 3'd1,
    S_LOAD2 = 3'd2,
    S_ITER  = 3'd3,
    S_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/one_hot_detect.sv
// Classifies the neuron activity flags: exactly one set, none set, lowest set index.
module one_hot_detect
  import maxnet_pkg::*;
(
  input  logic [N_NODES-1:0] flags,
  output logic               count_is_one,
  output logic               count_is_zero,
  output logic [IDX_W-1:0]   low_idx
);
  assign count_is_zero = (flags == '0);
  // Clearing the lowest set bit leaves zero only for a power of two.
  assign count_is_one  = !count_is_zero && ((flags & (flags - 1'b1)) == '0);

  always_comb begin
    low_idx = '0;
    for (int i = N_NODES - 1; i >= 0; i--) begin
      if (flags[i]) low_idx = IDX_W'(i);
    end
  end
endmodule

// File: rtl/maxnet_ctrl.sv
// Load/feedback sequencer for the 4-neuron maxnet; reports winner, no-winner or timeout.
module maxnet_ctrl
  import maxnet_pkg::*;
#(
  parameter int MAX_ITER = 64,
  parameter int ITER_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] o,
  input  logic [DATA_W-1:0]  xo0,
  input  logic [DATA_W-1:0]  xo1,
  input  logic [DATA_W-1:0]  xo2,
  input  logic [DATA_W-1:0]  xo3,
  output logic               mux,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   winner,
  output logic [DATA_W-1:0]  winner_val,
  output logic               no_winner,
  output logic               timeout
);
  state_e              state_q, state_d;
  logic [ITER_W-1:0]   iter_cnt_q, iter_cnt_d;
  logic                mux_q, mux_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [IDX_W-1:0]    winner_q, winner_d;
  logic [DATA_W-1:0]   winner_val_q, winner_val_d;
  logic                no_winner_q, no_winner_d;
  logic                timeout_q, timeout_d;

  logic                is_one, is_zero;
  logic [IDX_W-1:0]    low_idx;
  logic [DATA_W-1:0]   xo_arr [N_NODES];
  logic                last_iter;

  assign xo_arr[0] = xo0;
  assign xo_arr[1] = xo1;
  assign xo_arr[2] = xo2;
  assign xo_arr[3] = xo3;

  assign last_iter = (iter_cnt_q == ITER_W'(MAX_ITER - 1));

  one_hot_detect u_ohd (
    .flags         (o),
    .count_is_one  (is_one),
    .count_is_zero (is_zero),
    .low_idx       (low_idx)
  );

  always_comb begin
    state_d      = state_q;
    iter_cnt_d   = iter_cnt_q;
    winner_d     = winner_q;
    winner_val_d = winner_val_q;
    no_winner_d  = no_winner_q;
    timeout_d    = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_LOAD1;
          iter_cnt_d   = '0;
          winner_d     = '0;
          winner_val_d = '0;
          no_winner_d  = 1'b0;
          timeout_d    = 1'b0;
        end
      end
      S_LOAD1: state_d = S_LOAD2;
      S_LOAD2: state_d = S_ITER;
      S_ITER: begin
        // Single survivor wins over timeout when both happen on the last step.
        if (is_one) begin
          state_d      = S_DONE;
          winner_d     = low_idx;
          winner_val_d = xo_arr[low_idx];
        end else if (is_zero) begin
          state_d      = S_DONE;
          no_winner_d  = 1'b1;
          winner_d     = '0;
          winner_val_d = '0;
        end else if (last_iter) begin
          state_d      = S_DONE;
          timeout_d    = 1'b1;
          winner_d     = low_idx;
          winner_val_d = xo_arr[low_idx];
        end else begin
          iter_cnt_d   = iter_cnt_q + ITER_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they move with transitions.
  always_comb begin
    mux_d  = (state_d == S_ITER) || (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      iter_cnt_q   <= '0;
      mux_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      winner_q     <= '0;
      winner_val_q <= '0;
      no_winner_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      iter_cnt_q   <= iter_cnt_d;
      mux_q        <= mux_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      winner_q     <= winner_d;
      winner_val_q <= winner_val_d;
      no_winner_q  <= no_winner_d;
      timeout_q    <= timeout_d;
    end
  end

  assign mux        = mux_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign winner     = winner_q;
  assign winner_val = winner_val_q;
  assign no_winner  = no_winner_q;
  assign timeout    = timeout_q;
endmodule
